// File: rtl/fetch_redirect_ctrl_if.sv
// Fetch-redirect handshake bundle.
// master: hazard unit / pipeline side that drives the stall and branch controls and
//         consumes the fetch state.
// slave : fetch_redirect_ctrl, which owns the PC, IF/ID, predictor and counters.
// Ports carried: stall/noop/pc_write controls, fetched instruction, ID branch info,
// EX branch resolution, and PC, IF/ID, prediction, bubble, flush, predictor-state
// and performance-counter outputs.
interface fetch_redirect_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic              stall_i;
  logic              noop_i;
  logic              pc_write_i;
  logic [31:0]       instr_i;
  logic              id_branch_i;
  logic [31:0]       id_target_i;
  logic              ex_branch_valid_i;
  logic              ex_taken_i;
  logic              ex_pred_taken_i;
  logic [31:0]       ex_target_i;
  logic [31:0]       ex_pc_plus4_i;
  logic [31:0]       pc_o;
  logic [31:0]       if_id_pc_o;
  logic [31:0]       if_id_instr_o;
  logic              if_id_valid_o;
  logic              pred_taken_o;
  logic              id_ex_bubble_o;
  logic              flush_o;
  logic [1:0]        pred_state_o;
  logic [CNT_W-1:0]  stall_cnt_o;
  logic [CNT_W-1:0]  flush_cnt_o;

  modport master (
    output stall_i, noop_i, pc_write_i, instr_i, id_branch_i, id_target_i,
           ex_branch_valid_i, ex_taken_i, ex_pred_taken_i, ex_target_i, ex_pc_plus4_i,
    input  pc_o, if_id_pc_o, if_id_instr_o, if_id_valid_o, pred_taken_o,
           id_ex_bubble_o, flush_o, pred_state_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  stall_i, noop_i, pc_write_i, instr_i, id_branch_i, id_target_i,
           ex_branch_valid_i, ex_taken_i, ex_pred_taken_i, ex_target_i, ex_pc_plus4_i,
    output pc_o, if_id_pc_o, if_id_instr_o, if_id_valid_o, pred_taken_o,
           id_ex_bubble_o, flush_o, pred_state_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/fetch_redirect_ctrl.sv
// Fetch front-end controller: applies load-use stall/noop/PC-write controls and EX
// branch resolution to the PC and IF/ID register, runs a 2-bit saturating branch
// predictor, requests ID/EX bubbles and keeps saturating stall/flush counters.
// Ports: clk_i (rising edge), rst_i (async, active-high), bus (slave modport of
// fetch_redirect_ctrl_if carrying all control, fetch and status signals).
module fetch_redirect_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  fetch_redirect_ctrl_if.slave  bus
);

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} pred_state_e;

  pred_state_e       state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       if_id_pc_q, if_id_instr_q;
  logic              if_id_valid_q;
  logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;
  logic              mispred, pred_taken, redirect;

  assign mispred    = bus.ex_branch_valid_i & (bus.ex_taken_i != bus.ex_pred_taken_i);
  assign pred_taken = bus.id_branch_i & if_id_valid_q & state_q[1];
  // A stalled or squashed ID branch must not steer fetch.
  assign redirect   = pred_taken & ~bus.stall_i & ~mispred;

  // Next-PC selection: mispredict recovery beats the PC-write hold.
  always_comb begin
    pc_d = pc_q + PC_STEP;
    if (mispred) begin
      pc_d = bus.ex_taken_i ? bus.ex_target_i : bus.ex_pc_plus4_i;
    end else if (!bus.pc_write_i) begin
      pc_d = pc_q;
    end else if (redirect) begin
      pc_d = bus.id_target_i;
    end
  end

  // Predictor next state: saturating up/down on each resolved branch.
  always_comb begin
    state_d = state_q;
    if (bus.ex_branch_valid_i) begin
      unique case (state_q)
        SNT:     state_d = bus.ex_taken_i ? WNT : SNT;
        WNT:     state_d = bus.ex_taken_i ? WT  : SNT;
        WT:      state_d = bus.ex_taken_i ? ST  : WNT;
        ST:      state_d = bus.ex_taken_i ? ST  : WT;
        default: state_d = WNT;
      endcase
    end
  end

  // Predictor state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= WNT;
    else       state_q <= state_d;
  end

  // PC and IF/ID; squash wins over stall since the held instruction is wrong-path.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q          <= RESET_PC;
      if_id_pc_q    <= 32'd0;
      if_id_instr_q <= NOP_INSTR;
      if_id_valid_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      if (mispred || redirect) begin
        if_id_pc_q    <= 32'd0;
        if_id_instr_q <= NOP_INSTR;
        if_id_valid_q <= 1'b0;
      end else if (!bus.stall_i) begin
        if_id_pc_q    <= pc_q;
        if_id_instr_q <= bus.instr_i;
        if_id_valid_q <= 1'b1;
      end
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (bus.stall_i && !mispred && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (mispred && (flush_cnt_q != {CNT_W{1'b1}})) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.pc_o           = pc_q;
  assign bus.if_id_pc_o     = if_id_pc_q;
  assign bus.if_id_instr_o  = if_id_instr_q;
  assign bus.if_id_valid_o  = if_id_valid_q;
  assign bus.pred_taken_o   = pred_taken;
  assign bus.id_ex_bubble_o = bus.noop_i | mispred | ~if_id_valid_q;
  assign bus.flush_o        = mispred;
  assign bus.pred_state_o   = state_q;
  assign bus.stall_cnt_o    = stall_cnt_q;
  assign bus.flush_cnt_o    = flush_cnt_q;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Self-checking bench for fetch_redirect_ctrl: directed vector table, hand-written
// reset/saturation sequences and random stimulus against a behavioural model.
// Two instances run in lockstep: CNT_W=16 and CNT_W=4 (counter saturation).
module tb_fetch_redirect_ctrl;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] INSN = 32'h0050_0093;

  typedef struct {
    logic        stall, noop, pcw;
    logic [31:0] instr;
    logic        idb;
    logic [31:0] idt;
    logic        exv, ext, expred;
    logic [31:0] ext_tgt, pc4;
  } in_t;

  typedef struct {
    in_t         in;
    logic [31:0] pc;
    logic        valid;
    logic [1:0]  pred;
    logic        flush, bubble;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  in_t  cur;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  logic [31:0] m_pc, m_ifpc, m_ifinstr;
  logic        m_valid;
  int          m_pred, m_scnt, m_fcnt;

  always #5 clk = ~clk;

  fetch_redirect_ctrl_if #(.CNT_W(16)) b16 ();
  fetch_redirect_ctrl_if #(.CNT_W(4))  b4 ();

  assign b16.stall_i = cur.stall;            assign b4.stall_i = cur.stall;
  assign b16.noop_i = cur.noop;              assign b4.noop_i = cur.noop;
  assign b16.pc_write_i = cur.pcw;           assign b4.pc_write_i = cur.pcw;
  assign b16.instr_i = cur.instr;            assign b4.instr_i = cur.instr;
  assign b16.id_branch_i = cur.idb;          assign b4.id_branch_i = cur.idb;
  assign b16.id_target_i = cur.idt;          assign b4.id_target_i = cur.idt;
  assign b16.ex_branch_valid_i = cur.exv;    assign b4.ex_branch_valid_i = cur.exv;
  assign b16.ex_taken_i = cur.ext;           assign b4.ex_taken_i = cur.ext;
  assign b16.ex_pred_taken_i = cur.expred;   assign b4.ex_pred_taken_i = cur.expred;
  assign b16.ex_target_i = cur.ext_tgt;      assign b4.ex_target_i = cur.ext_tgt;
  assign b16.ex_pc_plus4_i = cur.pc4;        assign b4.ex_pc_plus4_i = cur.pc4;

  fetch_redirect_ctrl #(.CNT_W(16)) u_dut16 (.clk_i(clk), .rst_i(rst), .bus(b16));
  fetch_redirect_ctrl #(.CNT_W(4))  u_dut4  (.clk_i(clk), .rst_i(rst), .bus(b4));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic in_t mk(input logic stall, input logic noop, input logic pcw,
                             input logic idb, input logic [31:0] idt, input logic exv,
                             input logic ext, input logic expred, input logic [31:0] pc4);
    in_t r;
    r.stall = stall; r.noop = noop; r.pcw = pcw; r.instr = INSN;
    r.idb = idb; r.idt = idt; r.exv = exv; r.ext = ext; r.expred = expred;
    r.ext_tgt = 32'h200; r.pc4 = pc4;
    return r;
  endfunction

  function automatic vec_t mv(input in_t in, input logic [31:0] pc, input logic valid,
                              input logic [1:0] pred, input logic flush, input logic bubble);
    vec_t v;
    v.in = in; v.pc = pc; v.valid = valid; v.pred = pred; v.flush = flush; v.bubble = bubble;
    return v;
  endfunction

  function automatic int sat(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_ifpc = 32'h0; m_ifinstr = NOP; m_valid = 1'b0;
    m_pred = 1; m_scnt = 0; m_fcnt = 0;
  endtask

  // Compare every DUT output with the model for the inputs currently applied.
  task automatic check_model();
    bit mis, pt;
    mis = cur.exv && (cur.ext != cur.expred);
    pt  = cur.idb && m_valid && (m_pred >= 2);
    chk("pc",         b16.pc_o,           m_pc);
    chk("if_id_pc",   b16.if_id_pc_o,     m_ifpc);
    chk("if_id_inst", b16.if_id_instr_o,  m_ifinstr);
    chk("if_id_vld",  32'(b16.if_id_valid_o), 32'(m_valid));
    chk("pred_state", 32'(b16.pred_state_o),  m_pred);
    chk("stall_cnt",  32'(b16.stall_cnt_o),   sat(m_scnt, 65535));
    chk("flush_cnt",  32'(b16.flush_cnt_o),   sat(m_fcnt, 65535));
    chk("stall_cnt4", 32'(b4.stall_cnt_o),    sat(m_scnt, 15));
    chk("flush_cnt4", 32'(b4.flush_cnt_o),    sat(m_fcnt, 15));
    chk("flush",      32'(b16.flush_o),       32'(mis));
    chk("pred_taken", 32'(b16.pred_taken_o),  32'(pt));
    chk("bubble",     32'(b16.id_ex_bubble_o), 32'(cur.noop || mis || !m_valid));
    chk("pc4inst",    b4.pc_o,            m_pc);
  endtask

  // Advance the model by one clock edge using the applied inputs.
  task automatic model_step();
    bit mis, redir;
    mis   = cur.exv && (cur.ext != cur.expred);
    redir = cur.idb && m_valid && (m_pred >= 2) && !cur.stall && !mis;
    if (cur.stall && !mis) m_scnt++;
    if (mis) m_fcnt++;
    if (cur.exv) m_pred = cur.ext ? ((m_pred == 3) ? 3 : m_pred + 1)
                                  : ((m_pred == 0) ? 0 : m_pred - 1);
    if (mis || redir) begin
      m_ifpc = 32'h0; m_ifinstr = NOP; m_valid = 1'b0;
    end else if (!cur.stall) begin
      m_ifpc = m_pc; m_ifinstr = cur.instr; m_valid = 1'b1;
    end
    if (mis)           m_pc = cur.ext ? cur.ext_tgt : cur.pc4;
    else if (!cur.pcw) m_pc = m_pc;
    else if (redir)    m_pc = cur.idt;
    else               m_pc = m_pc + 32'd4;
  endtask

  // Called just after a negedge; returns just after the following negedge.
  task automatic cycle(input in_t v);
    cur = v;
    #1;
    check_model();
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cur = mk(0, 0, 1, 0, 0, 0, 0, 0, 0);
    #1;
    model_reset();
    check_model();
    @(posedge clk); #1;
    check_model();
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t vecs[16];

  initial begin
    in_t fr, tk, nt;
    fr = mk(0, 0, 1, 0, 32'h0, 0, 0, 0, 32'h0);
    tk = mk(0, 0, 1, 0, 32'h0, 1, 1, 1, 32'h0);
    nt = mk(0, 0, 1, 0, 32'h0, 1, 0, 0, 32'h0);
    vecs[0]  = mv(fr, 32'h04, 1, 2'b01, 0, 1);
    vecs[1]  = mv(fr, 32'h08, 1, 2'b01, 0, 0);
    vecs[2]  = mv(fr, 32'h0C, 1, 2'b01, 0, 0);
    vecs[3]  = mv(fr, 32'h10, 1, 2'b01, 0, 0);
    vecs[4]  = mv(mk(1, 1, 0, 0, 0, 0, 0, 0, 0), 32'h10, 1, 2'b01, 0, 1);
    vecs[5]  = mv(fr, 32'h14, 1, 2'b01, 0, 0);
    vecs[6]  = mv(tk, 32'h18, 1, 2'b10, 0, 0);
    vecs[7]  = mv(tk, 32'h1C, 1, 2'b11, 0, 0);
    vecs[8]  = mv(tk, 32'h20, 1, 2'b11, 0, 0);
    vecs[9]  = mv(tk, 32'h24, 1, 2'b11, 0, 0);
    vecs[10] = mv(mk(0, 0, 1, 1, 32'h100, 0, 0, 0, 0), 32'h100, 0, 2'b11, 0, 0);
    vecs[11] = mv(nt, 32'h104, 1, 2'b10, 0, 1);
    vecs[12] = mv(nt, 32'h108, 1, 2'b01, 0, 0);
    vecs[13] = mv(nt, 32'h10C, 1, 2'b00, 0, 0);
    vecs[14] = mv(nt, 32'h110, 1, 2'b00, 0, 0);
    vecs[15] = mv(mk(1, 0, 0, 0, 0, 1, 0, 1, 32'h2C), 32'h2C, 0, 2'b00, 1, 1);

    cur = fr;
    @(negedge clk);
    do_reset();

    // Directed table: load-use, predictor saturation, redirect, mispredict+stall.
    for (int i = 0; i < 16; i++) begin
      cur = vecs[i].in;
      #1;
      check_model();
      chk($sformatf("v%0d_flush", i),  32'(b16.flush_o),        32'(vecs[i].flush));
      chk($sformatf("v%0d_bubble", i), 32'(b16.id_ex_bubble_o), 32'(vecs[i].bubble));
      model_step();
      @(posedge clk); #1;
      chk($sformatf("v%0d_pc", i),    b16.pc_o,                 vecs[i].pc);
      chk($sformatf("v%0d_valid", i), 32'(b16.if_id_valid_o),   32'(vecs[i].valid));
      chk($sformatf("v%0d_pred", i),  32'(b16.pred_state_o),    32'(vecs[i].pred));
      if (i == 4)  chk("loaduse_stall_cnt", 32'(b16.stall_cnt_o), 32'd1);
      if (i == 15) begin
        chk("mispred_flush_cnt", 32'(b16.flush_cnt_o), 32'd1);
        chk("mispred_stall_cnt", 32'(b16.stall_cnt_o), 32'd1);
        chk("mispred_ifid_inst", b16.if_id_instr_o, NOP);
      end
      @(negedge clk);
    end

    // 20 stall cycles: the 4-bit counter pins at 4'hF.
    for (int i = 0; i < 20; i++) cycle(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("stall_sat4",  32'(b4.stall_cnt_o),  32'hF);
    chk("stall_cnt16", 32'(b16.stall_cnt_o), 32'd21);

    // Run PC up to 0x40, then reset mid-run and restart.
    for (int i = 0; i < 5; i++) cycle(fr);
    #1;
    chk("pre_reset_pc", b16.pc_o, 32'h40);
    do_reset();
    chk("rst_pc",    b16.pc_o,          32'h0);
    chk("rst_instr", b16.if_id_instr_o, NOP);
    chk("rst_pred",  32'(b16.pred_state_o), 32'h1);
    chk("rst_cnt",   32'(b16.stall_cnt_o),  32'h0);
    for (int i = 0; i < 3; i++) cycle(fr);
    #1;
    chk("post_rst_pc",    b16.pc_o,       32'hC);
    chk("post_rst_ifpc",  b16.if_id_pc_o, 32'h8);
    chk("post_rst_valid", 32'(b16.if_id_valid_o), 32'h1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      in_t r;
      r.stall   = ($urandom_range(0, 4) == 0);
      r.noop    = ($urandom_range(0, 4) == 0);
      r.pcw     = ($urandom_range(0, 4) != 0);
      r.instr   = $urandom;
      r.idb     = ($urandom_range(0, 2) == 0);
      r.idt     = {$urandom_range(0, 65535), 2'b00} & 32'h0003_FFFC;
      r.exv     = ($urandom_range(0, 2) == 0);
      r.ext     = 1'($urandom_range(0, 1));
      r.expred  = 1'($urandom_range(0, 1));
      r.ext_tgt = $urandom & 32'hFFFF_FFFC;
      r.pc4     = $urandom & 32'hFFFF_FFFC;
      if (i == 200) r = mk(0, 0, 1, 0, 0, 1, 1, 0, 0);
      if (i == 201) begin
        r = mk(0, 0, 1, 0, 0, 1, 1, 1, 0);
        r.ext_tgt = 32'hFFFF_FFFC;
      end
      cycle(r);
    end
    #1;
    check_model();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
